reg_file_mp: RTL

- Parametrised multi-port register file: successor to the single-write, two-read core register file.
- Adds configurable depth and read-port count, plus a second write port for the late writeback path (loads/mul).
- Adds a per-register busy scoreboard with an issue handshake, so the decode stage can stall on pending long-latency writes.
- Sits between decode (reads, issue) and the execute/memory writeback stages.

---
 rtl/reg_file_mp.sv | 131 +++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//   Multi-port register file with a per-register busy scoreboard.
//   Two write ports: A = early/ALU writeback, B = late/memory writeback.
//   NREAD combinational read ports. Register 0 is hardwired to zero.
//   An accepted issue marks its destination busy. A port B write with
//   wb_clr clears that busy bit.
//
// Optional feature (macro REG_FILE_MP_BYPASS_EN):
//   When defined, same-cycle write data is forwarded to the read ports
//   (priority A, then B, then stored). A same-cycle port B clear is also
//   seen by rd_busy and iss_ready, so issue can follow writeback with no
//   bubble. When undefined, reads see only registered state.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   rd_addr    NREAD read addresses, port i at [i*AW +: AW]
//   rd_data    NREAD read data,      port i at [i*WIDTH +: WIDTH]
//   rd_busy    busy flag of each read port's register
//   wa_*       write port A (we/addr/data)
//   wb_*       write port B (we/addr/data), wb_clr clears busy with wb_we
//   iss_valid  issue request for iss_addr
//   iss_addr   destination register of a long-latency instruction
//   iss_ready  iss_addr is free (or is r0)
//   busy_any   OR of all busy bits
// -----------------------------------------------------------------------------
module reg_file_mp #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   wa_we,
  input  logic [AW-1:0]          wa_addr,
  input  logic [WIDTH-1:0]       wa_data,
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_addr,
  input  logic [WIDTH-1:0]       wb_data,
  input  logic                   wb_clr,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_addr,
  output logic                   iss_ready,
  output logic                   busy_any
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic             wb_clr_v;
  logic             iss_accept;
  logic [AW-1:0]    ra [NREAD];

  assign wb_clr_v = wb_we && wb_clr;

  // iss_ready looks at the registered busy bit. With bypass, a clear in the
  // same cycle also frees the register.
  always_comb begin
    iss_ready = (iss_addr == '0) || !busy_q[iss_addr];
`ifdef REG_FILE_MP_BYPASS_EN
    if (wb_clr_v && (wb_addr == iss_addr)) iss_ready = 1'b1;
`endif
  end

  assign iss_accept = iss_valid && iss_ready;
  assign busy_any   = |busy_q;

  // Next-state: port A wins data on a collision. The busy set is applied
  // after the clear so that a simultaneous issue keeps the register busy.
  // Index 0 is never written, which keeps r0 and busy[0] at zero.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wa_we && (wa_addr == AW'(i)))
        regs_d[i] = wa_data;
      else if (wb_we && (wb_addr == AW'(i)))
        regs_d[i] = wb_data;
      if (wb_clr_v && (wb_addr == AW'(i)))
        busy_d[i] = 1'b0;
      if (iss_accept && (iss_addr == AW'(i)))
        busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  // Read ports
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NREAD; p++) begin
      ra[p] = rd_addr[p*AW +: AW];
      rd_data[p*WIDTH +: WIDTH] = regs_q[ra[p]];
      rd_busy[p]                = busy_q[ra[p]];
`ifdef REG_FILE_MP_BYPASS_EN
      if (wa_we && (wa_addr == ra[p]))
        rd_data[p*WIDTH +: WIDTH] = wa_data;
      else if (wb_we && (wb_addr == ra[p]))
        rd_data[p*WIDTH +: WIDTH] = wb_data;
      if (wb_clr_v && (wb_addr == ra[p]))
        rd_busy[p] = 1'b0;
`endif
      if (ra[p] == '0) begin
        rd_data[p*WIDTH +: WIDTH] = '0;
        rd_busy[p]                = 1'b0;
      end
      // Forwarded write data must not leak out while reset is held.
      if (!rst) begin
        rd_data[p*WIDTH +: WIDTH] = '0;
        rd_busy[p]                = 1'b0;
      end
    end
  end

endmodule
